// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// MMIO store path between the Memory stage and the UART transmitter.
interface mmio_uart_tx_if;

  logic        mmio_wea;
  logic [31:0] mmio_dat;
  logic        mmio_read;

  modport master (output mmio_wea, output mmio_dat, input mmio_read);
  modport slave  (input mmio_wea, input mmio_dat, output mmio_read);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit so full and empty are exact.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO-fed UART transmitter: queued store bytes go out as 8N1 frames, LSB first.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic           clk,
  input  logic           Rst,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           tx_busy,
  output logic           tx_overflow
);

  localparam int                CW        = $clog2(CLKS_PER_BIT);
  localparam int                BW        = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0]     BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]     BIT_LAST  = BW'(UART_DATA_BITS - 1);

  uart_tx_state_t            state, state_n;
  logic [CW-1:0]             baud_cnt, baud_cnt_n;
  logic [BW-1:0]             bit_idx, bit_idx_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic                      tx_n;
  logic                      baud_done;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_dout;

  // Full is taken from the registered pointers, so a same-cycle pop cannot rescue a store.
  assign fifo_push = bus.mmio_wea && !fifo_full;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .Rst   (Rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.mmio_dat[UART_DATA_BITS-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_done     = (baud_cnt == BAUD_LAST);
  assign bus.mmio_read = !fifo_full;
  assign tx_busy       = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    tx_n       = tx;
    fifo_pop   = 1'b0;
    if (state != IDLE) baud_cnt_n = baud_done ? '0 : baud_cnt + CW'(1);
    // tx_n is the line level for the cycle after this edge, keeping tx glitch-free.
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_n    = fifo_dout;
          baud_cnt_n = '0;
          state_n    = START;
          tx_n       = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          state_n   = DATA;
          bit_idx_n = '0;
          tx_n      = shift[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          shift_n = shift >> 1;
          if (bit_idx == BIT_LAST) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + BW'(1);
            tx_n      = shift[1];
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_n  = fifo_dout;
            state_n  = START;
            tx_n     = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      tx          <= 1'b1;
      tx_overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      tx       <= tx_n;
      if (bus.mmio_wea && fifo_full) tx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_n;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: table-driven single frames, hand sequences, random stream vs a UART receiver model.
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk;
  logic Rst;
  logic tx;
  logic tx_busy;
  logic tx_overflow;
  int   cyc;

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .Rst         (Rst),
    .bus         (bus_if),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_overflow (tx_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Receiver model: a frame is 10 bit slots of CPB samples; every sample in a slot must agree.
  logic [7:0] byte_q [$];
  bit         bad_q  [$];
  int         start_q[$];
  bit         mon_active;
  int         mon_pos;
  int         mon_slot;
  logic [7:0] mon_bits;
  bit         mon_bad;

  initial mon_active = 1'b0;

  always @(negedge clk) begin
    if (Rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_pos    = 1;
        mon_bits   = '0;
        mon_bad    = 1'b0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_slot = mon_pos / CPB;
      if (mon_slot == 0) begin
        if (tx !== 1'b0) mon_bad = 1'b1;
      end else if (mon_slot <= 8) begin
        if (mon_pos % CPB == 0) mon_bits[mon_slot-1] = tx;
        else if (tx !== mon_bits[mon_slot-1]) mon_bad = 1'b1;
      end else begin
        if (tx !== 1'b1) mon_bad = 1'b1;
      end
      mon_pos++;
      if (mon_pos == FRAME) begin
        byte_q.push_back(mon_bits);
        bad_q.push_back(mon_bad);
        mon_active = 1'b0;
      end
    end
  end

  int n_run;
  int n_fail;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] d);
    bus_if.mmio_wea = 1'b1;
    bus_if.mmio_dat = d;
    tick();
    bus_if.mmio_wea = 1'b0;
  endtask

  task automatic clear_rx();
    byte_q.delete();
    bad_q.delete();
    start_q.delete();
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    tick();
    clear_rx();
  endtask

  task automatic wait_rx(input string nm, input int n, input int budget);
    int k;
    k = 0;
    while (byte_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({nm, "_rx_count"}, 32'(byte_q.size() >= n), 32'd1);
  endtask

  typedef struct {
    logic [31:0] dat;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t        vecs[4];
  logic [7:0]  exp_q[$];
  int          c0;
  int          k;
  logic [31:0] r;

  initial begin
    vecs[0] = '{32'hDEAD_BEA5, 8'hA5};
    vecs[1] = '{32'h0000_0000, 8'h00};
    vecs[2] = '{32'hFFFF_FF3C, 8'h3C};
    vecs[3] = '{32'h1234_5601, 8'h01};

    n_run  = 0;
    n_fail = 0;
    Rst    = 1'b1;
    bus_if.mmio_wea = 1'b0;
    bus_if.mmio_dat = '0;

    tick();
    check("rst_tx", tx, 1);
    check("rst_read", bus_if.mmio_read, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_ovf", tx_overflow, 0);
    Rst = 1'b0;
    tick();
    clear_rx();

    // Single frames: content, start latency and exact frame length.
    for (int i = 0; i < 4; i++) begin
      clear_rx();
      c0 = cyc;
      store(vecs[i].dat);
      wait_rx($sformatf("vec%0d", i), 1, FRAME + 20);
      check($sformatf("vec%0d_byte", i), byte_q[0], vecs[i].exp_byte);
      check($sformatf("vec%0d_bits", i), bad_q[0], 0);
      check($sformatf("vec%0d_start", i), start_q[0], c0 + 2);
      check($sformatf("vec%0d_busy_last", i), tx_busy, 1);
      tick();
      check($sformatf("vec%0d_busy_end", i), tx_busy, 0);
      check($sformatf("vec%0d_tx_idle", i), tx, 1);
    end

    // Back-to-back frames with no idle gap.
    clear_rx();
    c0 = cyc;
    bus_if.mmio_wea = 1'b1;
    bus_if.mmio_dat = 32'h0000_0000;
    tick();
    bus_if.mmio_dat = 32'h0000_00FF;
    tick();
    bus_if.mmio_wea = 1'b0;
    wait_rx("b2b", 2, 2 * FRAME + 20);
    check("b2b_byte0", byte_q[0], 8'h00);
    check("b2b_byte1", byte_q[1], 8'hFF);
    check("b2b_start0", start_q[0], c0 + 2);
    check("b2b_gap", start_q[1] - start_q[0], FRAME);
    check("b2b_bits", 32'(bad_q[0] | bad_q[1]), 0);

    // Six consecutive stores: one popped, four fill the FIFO, sixth dropped.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus_if.mmio_wea = 1'b1;
      bus_if.mmio_dat = {24'hABCDEF, 8'h10 + 8'(i)};
      tick();
      check($sformatf("six_read_%0d", i), bus_if.mmio_read, (i >= 4) ? 0 : 1);
      check($sformatf("six_ovf_%0d", i), tx_overflow, (i == 5) ? 1 : 0);
    end
    bus_if.mmio_wea = 1'b0;
    wait_rx("six", 5, 5 * FRAME + 40);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("six_byte_%0d", i), byte_q[i], 8'h10 + 8'(i));
      check($sformatf("six_bits_%0d", i), bad_q[i], 0);
    end
    for (int i = 1; i < 5; i++)
      check($sformatf("six_gap_%0d", i), start_q[i] - start_q[i-1], FRAME);
    repeat (2 * FRAME) tick();
    check("six_total", byte_q.size(), 5);
    check("six_ovf_sticky", tx_overflow, 1);
    check("six_busy_end", tx_busy, 0);

    // Store the moment space reappears after a pop.
    do_reset();
    for (int i = 0; i < 5; i++) store({24'h0, 8'h20 + 8'(i)});
    check("reass_full", bus_if.mmio_read, 0);
    k = 0;
    while (!bus_if.mmio_read && k < 3 * FRAME) begin
      tick();
      k++;
    end
    check("reass_seen", bus_if.mmio_read, 1);
    store(32'hFFFF_FF55);
    check("reass_ovf", tx_overflow, 0);
    wait_rx("reass", 6, 6 * FRAME + 40);
    for (int i = 0; i < 5; i++)
      check($sformatf("reass_byte_%0d", i), byte_q[i], 8'h20 + 8'(i));
    check("reass_byte_5", byte_q[5], 8'h55);
    check("reass_ovf_end", tx_overflow, 0);

    // Random stream gated on mmio_read against an in-order byte queue.
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 700; i++) begin
      if (bus_if.mmio_read && $urandom_range(0, 1) == 1) begin
        r = $urandom;
        bus_if.mmio_wea = 1'b1;
        bus_if.mmio_dat = r;
        exp_q.push_back(r[7:0]);
      end else begin
        bus_if.mmio_wea = 1'b0;
      end
      tick();
    end
    bus_if.mmio_wea = 1'b0;
    wait_rx("rand", exp_q.size(), (exp_q.size() + 2) * FRAME);
    check("rand_count", byte_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("rand_byte_%0d", i), byte_q[i], exp_q[i]);
      check($sformatf("rand_bits_%0d", i), bad_q[i], 0);
    end
    check("rand_ovf", tx_overflow, 0);

    // Reset in the middle of a frame drops the frame and the queued bytes.
    do_reset();
    store(32'h0000_0000);
    store(32'h0000_0077);
    store(32'h0000_0066);
    repeat (12) tick();
    check("mid_tx_low", tx, 0);
    Rst = 1'b1;
    #1;
    check("mid_tx_async", tx, 1);
    check("mid_busy_rst", tx_busy, 0);
    check("mid_read_rst", bus_if.mmio_read, 1);
    tick();
    tick();
    Rst = 1'b0;
    tick();
    check("mid_busy_after", tx_busy, 0);
    check("mid_tx_after", tx, 1);
    clear_rx();
    repeat (3 * FRAME) tick();
    check("mid_no_frames", byte_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
